// File: rtl/conv_out_packer_if.sv
// Packed word stream from conv_out_packer to a frame writer or DMA engine.
// m_valid/m_ready handshake; m_last marks the final word of a frame.
interface conv_out_packer_if;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/conv_out_packer.sv
// conv_out_packer: crops the two wrapped-window columns from each row of the
// 3x3 convolution result stream, packs kept pixels four per 32-bit word
// (earliest pixel in [7:0]) and buffers words in a small FIFO feeding a
// valid/ready master port with an end-of-frame marker.
// Optional feature macro: CONV_PACK_CHECKSUM_EN adds a 16-bit per-frame
// checksum output of the kept pixels.
module conv_out_packer #(
  parameter int unsigned IMG_WIDTH  = 128,
  parameter int unsigned IMG_HEIGHT = 128,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              valid_in,
  input  logic [7:0]        data_in,
  output logic              frame_done,
  output logic              overflow,
`ifdef CONV_PACK_CHECKSUM_EN
  output logic [15:0]       checksum,
`endif
  conv_out_packer_if.master m
);

  localparam int unsigned ColW = $clog2(IMG_WIDTH);
  localparam int unsigned RowW = (IMG_HEIGHT - 2 > 1) ? $clog2(IMG_HEIGHT - 2) : 1;
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam logic [ColW-1:0] ColMax = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] RowMax = RowW'(IMG_HEIGHT - 3);

  logic [ColW-1:0]  col_q, col_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      word_q, word_d;
  logic [31:0]      merged;
  logic             keep, last_sample, push;

  logic [32:0]      mem [FIFO_DEPTH];
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic [32:0]      head;
  logic             empty, full, pop, wr_en, drop;
  logic             overflow_q;

  // Crop, pack and frame-position next state
  always_comb begin
    keep        = (col_q >= ColW'(2));
    last_sample = (col_q == ColMax) && (row_q == RowMax);
    merged      = word_q;
    if (keep) merged[{lane_q, 3'b000} +: 8] = data_in;
    push   = valid_in && ((keep && (lane_q == 2'd3)) || last_sample);
    col_d  = col_q;
    row_d  = row_q;
    lane_d = lane_q;
    word_d = word_q;
    if (valid_in) begin
      if (col_q == ColMax) begin
        col_d = '0;
        row_d = (row_q == RowMax) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (push) begin
        // Cleared word guarantees zeroed unfilled lanes on a partial last word
        lane_d = 2'd0;
        word_d = '0;
      end else if (keep) begin
        lane_d = lane_q + 2'd1;
        word_d = merged;
      end
    end
  end

  // FIFO status, handshake and head presentation
  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    head       = mem[rd_ptr_q[AddrW-1:0]];
    pop        = !empty && m.m_ready;
    // A simultaneous pop frees the slot being written, so full+pop never drops
    wr_en      = push && (!full || pop);
    drop       = push && full && !pop;
    frame_done = pop && head[32];
  end

  assign m.m_valid = !empty;
  assign m.m_data  = empty ? 32'd0 : head[31:0];
  assign m.m_last  = !empty && head[32];
  assign overflow  = overflow_q;

  // Position, packer, pointer and sticky-overflow registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      col_q      <= '0;
      row_q      <= '0;
      lane_q     <= '0;
      word_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      lane_q <= lane_d;
      word_q <= word_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop)  overflow_q <= 1'b1;
    end
  end

  // FIFO storage: {last, data}; contents are masked at the output when empty
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_ptr_q[AddrW-1:0]] <= {last_sample, merged};
  end

`ifdef CONV_PACK_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  logic [15:0] checksum_q;

  // Running sum of kept pixels including the current one
  always_comb begin
    sum_d = sum_q;
    if (valid_in && keep) sum_d = sum_q + {8'd0, data_in};
  end

  // Accumulator clears at the frame boundary; output captures the final sum
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sum_q      <= '0;
      checksum_q <= '0;
    end else if (valid_in && last_sample) begin
      sum_q      <= '0;
      checksum_q <= sum_d;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = checksum_q;
`else
  // Checksum disabled: no accumulator and no checksum port.
`endif

endmodule

// File: tb/tb_conv_out_packer.sv
// Directed bench for conv_out_packer with an 8x5 frame (6x3 kept pixels).
// Two instances share the input stream: FIFO depth 8 and FIFO depth 4.
module tb_conv_out_packer;

  logic       Clk;
  logic       Rst;
  logic       valid_in;
  logic [7:0] data_in;
  logic       fd8, fd4, ovf8, ovf4;
`ifdef CONV_PACK_CHECKSUM_EN
  logic [15:0] cs8, cs4;
`endif

  conv_out_packer_if if8 ();
  conv_out_packer_if if4 ();

  conv_out_packer #(.IMG_WIDTH(8), .IMG_HEIGHT(5), .FIFO_DEPTH(8)) dut8 (
    .Clk        (Clk),
    .Rst        (Rst),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .frame_done (fd8),
    .overflow   (ovf8),
`ifdef CONV_PACK_CHECKSUM_EN
    .checksum   (cs8),
`endif
    .m          (if8)
  );

  conv_out_packer #(.IMG_WIDTH(8), .IMG_HEIGHT(5), .FIFO_DEPTH(4)) dut4 (
    .Clk        (Clk),
    .Rst        (Rst),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .frame_done (fd4),
    .overflow   (ovf4),
`ifdef CONV_PACK_CHECKSUM_EN
    .checksum   (cs4),
`endif
    .m          (if4)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Kept pixels of a 0..23 frame: 2-7, 10-15, 18-23; {last, data}
  logic [32:0] exp_words [5] = '{33'h0_05040302, 33'h0_0B0A0706, 33'h0_0F0E0D0C,
                                 33'h0_15141312, 33'h1_00001716};

  // Handshake logs: words accepted and the word index at each frame_done
  logic [32:0] q8 [$];
  logic [32:0] q4 [$];
  int          fdq8 [$];
  int          fdq4 [$];

  always @(negedge Clk) begin
    if (!Rst && if8.m_valid && if8.m_ready) begin
      if (fd8) fdq8.push_back(q8.size());
      q8.push_back({if8.m_last, if8.m_data});
    end
    if (!Rst && if4.m_valid && if4.m_ready) begin
      if (fd4) fdq4.push_back(q4.size());
      q4.push_back({if4.m_last, if4.m_data});
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
  endtask

  task automatic send(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b1;
      data_in  = 8'(start + i);
      @(posedge Clk);
      #1;
    end
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  int b8, b4, bf8, bf4;

  initial begin
    Rst        = 1'b1;
    valid_in   = 1'b0;
    data_in    = 8'd0;
    if8.m_ready = 1'b0;
    if4.m_ready = 1'b0;
    do_reset();

    // Reset state
    check_eq("rst_m_valid", 64'(if8.m_valid), 64'd0);
    check_eq("rst_m_last", 64'(if8.m_last), 64'd0);
    check_eq("rst_m_data", 64'(if8.m_data), 64'd0);
    check_eq("rst_frame_done", 64'(fd8), 64'd0);
    check_eq("rst_overflow", 64'(ovf8), 64'd0);
`ifdef CONV_PACK_CHECKSUM_EN
    check_eq("rst_checksum", 64'(cs8), 64'd0);
`endif

    // Streaming frame with m_ready held high
    if8.m_ready = 1'b1;
    if4.m_ready = 1'b1;
    b8 = q8.size(); bf8 = fdq8.size();
    send(0, 24);
    idle(10);
    check_eq("t1_count", 64'(q8.size() - b8), 64'd5);
    for (int i = 0; i < 5; i++)
      if (b8 + i < q8.size()) check_eq($sformatf("t1_word%0d", i), 64'(q8[b8+i]), 64'(exp_words[i]));
    check_eq("t1_fd_count", 64'(fdq8.size() - bf8), 64'd1);
    if (fdq8.size() > bf8) check_eq("t1_fd_index", 64'(fdq8[bf8] - b8), 64'd4);
    check_eq("t1_overflow", 64'(ovf8), 64'd0);
`ifdef CONV_PACK_CHECKSUM_EN
    check_eq("t1_checksum_hold", 64'(cs8), 64'h00E1);
`endif

    // Frame with m_ready low: depth 8 holds all, depth 4 drops the last word
    do_reset();
    if8.m_ready = 1'b0;
    if4.m_ready = 1'b0;
    for (int i = 0; i < 24; i++) begin
      valid_in = 1'b1;
      data_in  = 8'(i);
      @(posedge Clk);
      #1;
      if (i == 4) check_eq("t2_pre_valid", 64'(if8.m_valid), 64'd0);
      if (i == 5) begin
        check_eq("t2_latency_valid", 64'(if8.m_valid), 64'd1);
        check_eq("t2_latency_data", 64'(if8.m_data), 64'h05040302);
      end
      if (i == 22) check_eq("t2_d4_ovf_before", 64'(ovf4), 64'd0);
      if (i == 23) begin
        check_eq("t2_d4_ovf_after", 64'(ovf4), 64'd1);
`ifdef CONV_PACK_CHECKSUM_EN
        check_eq("t2_checksum", 64'(cs8), 64'h00E1);
`endif
      end
    end
    valid_in = 1'b0;
    idle(3);
    check_eq("t2_hold_valid", 64'(if8.m_valid), 64'd1);
    check_eq("t2_hold_data", 64'(if8.m_data), 64'h05040302);
    check_eq("t2_hold_last", 64'(if8.m_last), 64'd0);
    check_eq("t2_d8_ovf", 64'(ovf8), 64'd0);
    b8 = q8.size(); bf8 = fdq8.size();
    b4 = q4.size(); bf4 = fdq4.size();
    if8.m_ready = 1'b1;
    if4.m_ready = 1'b1;
    idle(10);
    check_eq("t2_d8_count", 64'(q8.size() - b8), 64'd5);
    for (int i = 0; i < 5; i++)
      if (b8 + i < q8.size()) check_eq($sformatf("t2_d8_word%0d", i), 64'(q8[b8+i]), 64'(exp_words[i]));
    check_eq("t2_d8_fd_count", 64'(fdq8.size() - bf8), 64'd1);
    check_eq("t2_d4_count", 64'(q4.size() - b4), 64'd4);
    for (int i = 0; i < 4; i++)
      if (b4 + i < q4.size()) check_eq($sformatf("t2_d4_word%0d", i), 64'(q4[b4+i]), 64'(exp_words[i]));
    check_eq("t2_d4_no_fd", 64'(fdq4.size() - bf4), 64'd0);
    check_eq("t2_d4_ovf_sticky", 64'(ovf4), 64'd1);
    do_reset();
    check_eq("t2_d4_ovf_rst", 64'(ovf4), 64'd0);

    // Depth 4 full when the last word pushes, with a pop in that same cycle
    if4.m_ready = 1'b0;
    b4 = q4.size(); bf4 = fdq4.size();
    for (int i = 0; i < 24; i++) begin
      valid_in = 1'b1;
      data_in  = 8'(i);
      if (i == 23) if4.m_ready = 1'b1;
      @(posedge Clk);
      #1;
      if (i == 22) check_eq("t3_full_valid", 64'(if4.m_valid), 64'd1);
    end
    valid_in = 1'b0;
    idle(10);
    check_eq("t3_ovf", 64'(ovf4), 64'd0);
    check_eq("t3_count", 64'(q4.size() - b4), 64'd5);
    for (int i = 0; i < 5; i++)
      if (b4 + i < q4.size()) check_eq($sformatf("t3_word%0d", i), 64'(q4[b4+i]), 64'(exp_words[i]));
    check_eq("t3_fd_count", 64'(fdq4.size() - bf4), 64'd1);

    // Reset mid-frame discards the held partial frame
    do_reset();
    if8.m_ready = 1'b0;
    send(100, 10);
    idle(1);
    check_eq("t4_pre_valid", 64'(if8.m_valid), 64'd1);
    check_eq("t4_pre_data", 64'(if8.m_data), 64'h69686766);
    do_reset();
    check_eq("t4_rst_valid", 64'(if8.m_valid), 64'd0);
    check_eq("t4_rst_data", 64'(if8.m_data), 64'd0);
`ifdef CONV_PACK_CHECKSUM_EN
    check_eq("t4_rst_checksum", 64'(cs8), 64'd0);
`endif
    b8 = q8.size(); bf8 = fdq8.size();
    if8.m_ready = 1'b1;
    send(0, 24);
    idle(10);
    check_eq("t4_count", 64'(q8.size() - b8), 64'd5);
    for (int i = 0; i < 5; i++)
      if (b8 + i < q8.size()) check_eq($sformatf("t4_word%0d", i), 64'(q8[b8+i]), 64'(exp_words[i]));
    check_eq("t4_fd_count", 64'(fdq8.size() - bf8), 64'd1);
`ifdef CONV_PACK_CHECKSUM_EN
    check_eq("t4_checksum", 64'(cs8), 64'h00E1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
